// File: rtl/led_pkg.sv
// Shared LED-driver definitions: channel mode encodings and the channel-index width helper.
package led_pkg;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_ON    = 2'd1;
  localparam logic [1:0] LED_PWM   = 2'd2;
  localparam logic [1:0] LED_BLINK = 2'd3;

  // Channel select width; a single channel still needs a 1-bit index port.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running power-of-two prescaler: one-cycle tick every 2^PRESCALE clk cycles.
module led_prescaler #(
  parameter int PRESCALE = 6
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // PRESCALE=0 still keeps a 1-bit counter so the port set is identical; tick is forced high.
  localparam int CW = (PRESCALE == 0) ? 1 : PRESCALE;

  logic [CW-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

  assign tick = (PRESCALE == 0) ? 1'b1 : (pre_cnt_q == '1);

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: per-channel OFF/ON/PWM/BLINK with shadowed settings committed at PWM period ends.
module led_pwm_bank
  import led_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int PWIDTH     = 8,
  parameter int PRESCALE   = 6,
  parameter int BLINK_DIV  = 7,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [chw(NCH)-1:0]  wr_ch,
  input  logic [1:0]           wr_mode,
  input  logic [PWIDTH-1:0]    wr_duty,
  output logic [NCH-1:0]       led,
  output logic                 period_start
);

  localparam int   CHW = chw(NCH);
  localparam logic AL  = (ACTIVE_LOW != 0);

  logic                       tick, period_end;
  logic [PWIDTH-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_DIV-1:0]       blink_cnt_q, blink_cnt_d;
  logic [NCH-1:0][1:0]        sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [NCH-1:0][PWIDTH-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [NCH-1:0]             led_q, led_d;
  logic                       period_start_q, period_start_d;
  logic                       blink_phase;

  led_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign period_end  = tick && (pwm_cnt_q == '1);
  assign blink_phase = blink_cnt_q[BLINK_DIV-1];

  always_comb begin
    pwm_cnt_d      = tick ? pwm_cnt_q + PWIDTH'(1) : pwm_cnt_q;
    blink_cnt_d    = period_end ? blink_cnt_q + BLINK_DIV'(1) : blink_cnt_q;
    period_start_d = period_end;
    // Commit takes the shadow as it stood before any write landing on this same edge.
    act_mode_d     = period_end ? sh_mode_q : act_mode_q;
    act_duty_d     = period_end ? sh_duty_q : act_duty_q;
    sh_mode_d      = sh_mode_q;
    sh_duty_d      = sh_duty_q;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && wr_ch == CHW'(i)) begin
        sh_mode_d[i] = wr_mode;
        sh_duty_d[i] = wr_duty;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic in_pwm, raw;
    always_comb begin
      in_pwm = pwm_cnt_q < act_duty_q[g];
      case (act_mode_q[g])
        LED_ON:    raw = 1'b1;
        LED_PWM:   raw = in_pwm;
        LED_BLINK: raw = in_pwm & blink_phase;
        default:   raw = 1'b0;
      endcase
      led_d[g] = raw ^ AL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      sh_mode_q      <= {NCH{LED_OFF}};
      sh_duty_q      <= '0;
      act_mode_q     <= {NCH{LED_OFF}};
      act_duty_q     <= '0;
      led_q          <= {NCH{AL}};
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      sh_mode_q      <= sh_mode_d;
      sh_duty_q      <= sh_duty_d;
      act_mode_q     <= act_mode_d;
      act_duty_q     <= act_duty_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed + random bench for led_pwm_bank against a time-based reference model (active-high and active-low copies).
module tb_led_pwm_bank;

  localparam int NCH = 3, PW = 4, PS = 2, BD = 2;
  localparam int PERIOD = 1 << (PW + PS);

  logic       clk, rst, wr_en;
  logic [1:0] wr_ch, wr_mode;
  logic [3:0] wr_duty;
  logic [2:0] led_a, led_b;
  logic       ps_a, ps_b;

  int errs = 0, checks = 0;

  // Reference state: edges since reset, shadow and active settings per channel.
  int m_t;
  int m_sh_mode[NCH], m_sh_duty[NCH], m_act_mode[NCH], m_act_duty[NCH];

  led_pwm_bank #(.NCH(NCH), .PWIDTH(PW), .PRESCALE(PS), .BLINK_DIV(BD), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_duty(wr_duty), .led(led_a), .period_start(ps_a));

  led_pwm_bank #(.NCH(NCH), .PWIDTH(PW), .PRESCALE(PS), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_duty(wr_duty), .led(led_b), .period_start(ps_b));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < NCH; i++) begin
      m_sh_mode[i] = 0; m_sh_duty[i] = 0; m_act_mode[i] = 0; m_act_duty[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, m_t, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict from pre-edge model state, advance model, compare.
  task automatic cyc(input bit en, input int ch, input int mode, input int duty);
    int pwm, ph;
    bit pe, on;
    logic [2:0] exp;
    wr_en = en; wr_ch = ch[1:0]; wr_mode = mode[1:0]; wr_duty = duty[3:0];
    pwm = (m_t >> PS) % (1 << PW);
    ph  = ((m_t / PERIOD) >> (BD - 1)) & 1;
    pe  = (m_t % PERIOD) == PERIOD - 1;
    for (int i = 0; i < NCH; i++) begin
      on = pwm < m_act_duty[i];
      case (m_act_mode[i])
        1:       exp[i] = 1'b1;
        2:       exp[i] = on;
        3:       exp[i] = on && ph == 1;
        default: exp[i] = 1'b0;
      endcase
    end
    @(posedge clk);
    if (pe)
      for (int i = 0; i < NCH; i++) begin
        m_act_mode[i] = m_sh_mode[i]; m_act_duty[i] = m_sh_duty[i];
      end
    if (en && ch < NCH) begin
      m_sh_mode[ch] = mode; m_sh_duty[ch] = duty;
    end
    m_t++;
    #1;
    check("led_hi", {1'b0, led_a}, {1'b0, exp});
    check("led_lo", {1'b0, led_b}, {1'b0, ~exp});
    check("pstart", {3'b0, ps_a}, {3'b0, pe});
    check("pstart_lo", {3'b0, ps_b}, {3'b0, pe});
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic to_period_end();
    int guard = 0;
    while ((m_t % PERIOD) != PERIOD - 1 && guard < PERIOD) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_led_hi"}, {1'b0, led_a}, 4'b0000);
    check({tag, "_led_lo"}, {1'b0, led_b}, 4'b0111);
    check({tag, "_pstart"}, {3'b0, ps_a}, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_duty = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst_hold");
    rst = 1'b0;
    #1;
    reset_checks("rst_rel");

    // PWM duty 4 on ch0 before first period end, then watch two periods.
    cyc(1, 0, 2, 4);
    idle(2 * PERIOD);

    // ON written mid-period to ch1 waits for the next commit.
    idle(PERIOD / 2 - (m_t % PERIOD));
    cyc(1, 1, 1, 0);
    idle(PERIOD);

    // Write landing exactly on the period-end cycle commits one period later.
    to_period_end();
    cyc(1, 2, 2, 8);
    idle(2 * PERIOD);

    // BLINK at max duty, observed across several blink phases; last write wins.
    cyc(1, 0, 2, 1);
    cyc(1, 0, 3, 15);
    idle(5 * PERIOD);

    // Random writes, including invalid channel 3.
    for (int k = 0; k < 8 * PERIOD; k++) begin
      if ($urandom_range(0, 3) == 0)
        cyc(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      else
        cyc(0, 0, 0, 0);
    end

    // Invalid channel write then async reset mid-period.
    idle(PERIOD / 3);
    cyc(1, 3, 1, 15);
    idle(5);
    rst = 1'b1;
    #2;
    reset_checks("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst_async_hold");
    rst = 1'b0;
    cyc(1, 1, 2, 15);
    idle(2 * PERIOD + 10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
